// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode patterns, FSM states, opcode classes
// and the datapath mux select encodings driven by the multi-cycle sequencer.
package legv8_pkg;

    // Fully specified 11-bit opcodes (instruction[31:21])
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    // CBZ and B carry immediate bits inside the opcode field, so they match under a mask
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_B     = 11'b00010100000;
    localparam logic [10:0] MASK_B   = 11'b11111100000;

    // ALU_op encodings handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    // ALU A-input select
    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_REG  = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    // ALU B-input select
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_BROFF = 2'b11;

    // PC source select
    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // Sequencer states, 4-bit encoding
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_SH   = 4'd3,
        ST_R_WB      = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_RD    = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WR    = 4'd8,
        ST_EXEC_CBZ  = 4'd9,
        ST_EXEC_B    = 4'd10
    } state_t;

    // Instruction classes used for DECODE dispatch
    typedef enum logic [2:0] {
        CLS_MEM_LD  = 3'd0,
        CLS_MEM_ST  = 3'd1,
        CLS_R_ARITH = 3'd2,
        CLS_R_SHIFT = 3'd3,
        CLS_CBZ     = 3'd4,
        CLS_B       = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    // True when op matches pattern on every bit set in mask
    function automatic logic match_masked(input logic [10:0] op,
                                          input logic [10:0] pattern,
                                          input logic [10:0] mask);
        return ((op & mask) == (pattern & mask));
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier: maps instruction[31:21] to the dispatch class.
module opcode_class
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   cls
);

    // Exact matches first, then the masked branch formats; anything else is illegal
    always_comb begin
        cls = CLS_ILLEGAL;
        if ((opcode == OP_LDUR)) begin
            cls = CLS_MEM_LD;
        end else if (opcode == OP_STUR) begin
            cls = CLS_MEM_ST;
        end else if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_ORR)) begin
            cls = CLS_R_ARITH;
        end else if ((opcode == OP_LSL) || (opcode == OP_LSR)) begin
            cls = CLS_R_SHIFT;
        end else if (match_masked(opcode, OP_CBZ, MASK_CBZ)) begin
            cls = CLS_CBZ;
        end else if (match_masked(opcode, OP_B, MASK_B)) begin
            cls = CLS_B;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle LEGv8 datapath: fetch/decode/execute/memory/
// writeback over one memory port with a ready handshake, plus a retire counter.
module multicycle_control
    import legv8_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ALU_op,
    output logic [10:0]      opcode_out,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg2loc,
    output logic             instr_done,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t            state;
    op_class_t         op_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_store;
    logic              mem_req;
    logic              timeout_hit;
    logic              unused_zero;

    // The zero flag gates the PC write inside the datapath; the sequencer never needs it
    assign unused_zero = zero;

    opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (op_cls)
    );

    // States that hold a memory request open until mem_ready
    assign mem_req = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    // Timeout fires on the WAIT_MAX-th consecutive unanswered cycle of one request
    assign timeout_hit = (WAIT_MAX > 0) && mem_req && !mem_ready &&
                         (wait_cnt == WAIT_W'(WAIT_MAX - 1));

    // Moore strobe decode from the state; handshake completions qualify the last cycle
    always_comb begin
        ALU_op        = ALUOP_ADD;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_REG;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg2loc       = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        mem_timeout   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_BROFF;
                illegal   = (op_cls == CLS_ILLEGAL);
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                ALU_op    = ALUOP_RTYPE;
            end
            ST_EXEC_SH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                ALU_op    = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                reg2loc   = 1'b1;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                reg2loc    = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC_CBZ: begin
                alu_src_a     = SRC_A_ZERO;
                alu_src_b     = SRC_B_REG;
                reg2loc       = 1'b1;
                ALU_op        = ALUOP_BRANCH;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            ST_EXEC_B: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_ALUOUT;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
        mem_timeout = timeout_hit;
        if (reset) begin
            ALU_op        = ALUOP_ADD;
            alu_src_a     = SRC_A_PC;
            alu_src_b     = SRC_B_REG;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = PCSRC_ALU;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            reg2loc       = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
            mem_timeout   = 1'b0;
        end
    end

    // State register, wait counter, opcode latch and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            wait_cnt   <= '0;
            opcode_out <= '0;
            is_store   <= 1'b0;
            retired    <= '0;
        end else begin
            if (instr_done) begin
                retired <= retired + CNT_W'(1);
            end

            if (mem_req && !mem_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    opcode_out <= opcode;
                    is_store   <= (op_cls == CLS_MEM_ST);
                    case (op_cls)
                        CLS_MEM_LD, CLS_MEM_ST: state <= ST_MEM_ADDR;
                        CLS_R_ARITH:            state <= ST_EXEC_R;
                        CLS_R_SHIFT:            state <= ST_EXEC_SH;
                        CLS_CBZ:                state <= ST_EXEC_CBZ;
                        CLS_B:                  state <= ST_EXEC_B;
                        default:                state <= ST_FETCH;
                    endcase
                end
                ST_EXEC_R, ST_EXEC_SH: begin
                    state <= ST_R_WB;
                end
                ST_MEM_ADDR: begin
                    state <= is_store ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        state <= ST_MEM_WB;
                    end else if (timeout_hit) begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready || timeout_hit) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for the multi-cycle LEGv8 control sequencer.
module tb_multicycle_control;

    // Opcodes written out by hand from the instruction set
    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LSL  = 11'b11010011011;
    localparam logic [10:0] T_LSR  = 11'b11010011010;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_CBZ  = 11'b10110100101;
    localparam logic [10:0] T_B    = 11'b00010110011;
    localparam logic [10:0] T_BAD  = 11'b00000000000;

    // Strobe bit positions within the 13-bit flag field
    localparam logic [12:0] PCW  = 13'h1000;
    localparam logic [12:0] PCC  = 13'h0800;
    localparam logic [12:0] PCS  = 13'h0400;
    localparam logic [12:0] IORD = 13'h0200;
    localparam logic [12:0] MRD  = 13'h0100;
    localparam logic [12:0] MWR  = 13'h0080;
    localparam logic [12:0] IRW  = 13'h0040;
    localparam logic [12:0] RGW  = 13'h0020;
    localparam logic [12:0] M2R  = 13'h0010;
    localparam logic [12:0] R2L  = 13'h0008;
    localparam logic [12:0] DONE = 13'h0004;
    localparam logic [12:0] ILL  = 13'h0002;
    localparam logic [12:0] TMO  = 13'h0001;

    // Expected {ALU_op, alu_src_a, alu_src_b, flags} per state/situation
    localparam logic [18:0] E_Z   = 19'h0;
    localparam logic [18:0] E_FW  = {2'b00, 2'b00, 2'b01, MRD};
    localparam logic [18:0] E_FR  = {2'b00, 2'b00, 2'b01, MRD | IRW | PCW};
    localparam logic [18:0] E_TMO = {2'b00, 2'b00, 2'b01, MRD | TMO};
    localparam logic [18:0] E_DEC = {2'b00, 2'b00, 2'b11, 13'h0};
    localparam logic [18:0] E_ILL = {2'b00, 2'b00, 2'b11, ILL};
    localparam logic [18:0] E_XR  = {2'b10, 2'b01, 2'b00, 13'h0};
    localparam logic [18:0] E_XS  = {2'b10, 2'b01, 2'b10, 13'h0};
    localparam logic [18:0] E_RWB = {6'b0, RGW | DONE};
    localparam logic [18:0] E_MA  = {2'b00, 2'b01, 2'b10, R2L};
    localparam logic [18:0] E_MRD = {6'b0, MRD | IORD};
    localparam logic [18:0] E_MWB = {6'b0, RGW | M2R | DONE};
    localparam logic [18:0] E_MWW = {6'b0, MWR | IORD | R2L};
    localparam logic [18:0] E_MWD = {6'b0, MWR | IORD | R2L | DONE};
    localparam logic [18:0] E_CBZ = {2'b01, 2'b10, 2'b00, R2L | PCC | PCS | DONE};
    localparam logic [18:0] E_B   = {6'b0, PCW | PCS | DONE};

    typedef struct {
        logic        rst;
        logic [10:0] op;
        logic        zero;
        logic        rdy;
        logic [18:0] exp;
        logic        chk_ret;
        logic [3:0]  exp_ret;
        string       tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  ALU_op;
    logic [10:0] opcode_out;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
    logic        ir_write, reg_write, mem_to_reg, reg2loc, instr_done, illegal, mem_timeout;
    logic [3:0]  retired;

    vec_t        vecs[$];
    logic [3:0]  ret_model;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(4), .WAIT_MAX(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ALU_op        (ALU_op),
        .opcode_out    (opcode_out),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .reg2loc       (reg2loc),
        .instr_done    (instr_done),
        .illegal       (illegal),
        .mem_timeout   (mem_timeout),
        .retired       (retired)
    );

    task automatic push(input logic rst, input logic [10:0] op, input logic z,
                        input logic rdy, input logic [18:0] e, input logic cr,
                        input string tag);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = z; v.rdy = rdy;
        v.exp = e; v.chk_ret = cr; v.exp_ret = ret_model; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic add_rtype(input logic [10:0] op, input logic shift, input string tag);
        push(1'b0, op, 1'b0, 1'b1, E_FR, 1'b1, {tag, "_fetch"});
        push(1'b0, op, 1'b0, 1'b1, E_DEC, 1'b1, {tag, "_decode"});
        push(1'b0, op, 1'b0, 1'b1, shift ? E_XS : E_XR, 1'b1, {tag, "_exec"});
        push(1'b0, op, 1'b0, 1'b1, E_RWB, 1'b1, {tag, "_wb"});
        ret_model = ret_model + 4'd1;
    endtask

    task automatic add_branch(input logic [10:0] op, input logic z,
                              input logic [18:0] e_exec, input string tag);
        push(1'b0, op, z, 1'b1, E_FR, 1'b1, {tag, "_fetch"});
        push(1'b0, op, z, 1'b1, E_DEC, 1'b1, {tag, "_decode"});
        push(1'b0, op, z, 1'b0, e_exec, 1'b1, {tag, "_exec"});
        ret_model = ret_model + 4'd1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        opcode    = v.op;
        zero      = v.zero;
        mem_ready = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [18:0] got;
        #1;
        got = {ALU_op, alu_src_a, alu_src_b,
               pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_write, mem_to_reg, reg2loc, instr_done, illegal, mem_timeout};
        checks++;
        if (got !== v.exp) begin
            failures++;
            $display("[TB] FAIL %s[%0d] strobes got=%05h expected=%05h", v.tag, idx, got, v.exp);
        end
        if (v.chk_ret) begin
            checks++;
            if (retired !== v.exp_ret) begin
                failures++;
                $display("[TB] FAIL %s[%0d] retired got=%0d expected=%0d",
                         v.tag, idx, retired, v.exp_ret);
            end
        end
    endtask

    initial begin
        ret_model = 4'd0;

        // Reset: strobes forced low, counter cleared after the first edge
        push(1'b1, T_ADD, 1'b0, 1'b1, E_Z, 1'b0, "reset0");
        push(1'b1, T_ADD, 1'b0, 1'b1, E_Z, 1'b1, "reset1");

        // R-type and shift instructions with an always-ready memory
        add_rtype(T_ADD, 1'b0, "add");
        add_rtype(T_LSL, 1'b1, "lsl");
        add_rtype(T_SUB, 1'b0, "sub");
        add_rtype(T_LSR, 1'b1, "lsr");
        add_rtype(T_AND, 1'b0, "and");
        add_rtype(T_ORR, 1'b0, "orr");

        // LDUR with three wait cycles in MEM_RD (8 cycles total); ready ignored in DECODE/MEM_ADDR
        push(1'b0, T_LDUR, 1'b0, 1'b1, E_FR,  1'b1, "ldur_fetch");
        push(1'b0, T_LDUR, 1'b0, 1'b0, E_DEC, 1'b1, "ldur_decode");
        push(1'b0, T_LDUR, 1'b0, 1'b1, E_MA,  1'b1, "ldur_addr");
        push(1'b0, T_LDUR, 1'b0, 1'b0, E_MRD, 1'b1, "ldur_wait1");
        push(1'b0, T_LDUR, 1'b0, 1'b0, E_MRD, 1'b1, "ldur_wait2");
        push(1'b0, T_LDUR, 1'b0, 1'b0, E_MRD, 1'b1, "ldur_wait3");
        push(1'b0, T_LDUR, 1'b0, 1'b1, E_MRD, 1'b1, "ldur_rd");
        push(1'b0, T_LDUR, 1'b0, 1'b0, E_MWB, 1'b1, "ldur_wb");
        ret_model = ret_model + 4'd1;

        // STUR with zero wait
        push(1'b0, T_STUR, 1'b0, 1'b1, E_FR,  1'b1, "stur_fetch");
        push(1'b0, T_STUR, 1'b0, 1'b1, E_DEC, 1'b1, "stur_decode");
        push(1'b0, T_STUR, 1'b0, 1'b1, E_MA,  1'b1, "stur_addr");
        push(1'b0, T_STUR, 1'b0, 1'b1, E_MWD, 1'b1, "stur_wr");
        ret_model = ret_model + 4'd1;

        // CBZ taken and not taken look identical to the sequencer; then B
        add_branch(T_CBZ, 1'b1, E_CBZ, "cbz_z1");
        add_branch(T_CBZ, 1'b0, E_CBZ, "cbz_z0");
        add_branch(T_B,   1'b0, E_B,   "b");

        // Illegal opcode: pulse in DECODE, back to FETCH, nothing retired
        push(1'b0, T_BAD, 1'b0, 1'b1, E_FR,  1'b1, "bad_fetch");
        push(1'b0, T_BAD, 1'b0, 1'b1, E_ILL, 1'b1, "bad_decode");

        // FETCH with memory stuck: timeout on the 4th wait cycle, then a fresh wait
        push(1'b0, T_STUR, 1'b0, 1'b0, E_FW,  1'b1, "to_wait1");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_FW,  1'b1, "to_wait2");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_FW,  1'b1, "to_wait3");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_TMO, 1'b1, "to_fire");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_FW,  1'b1, "to_restart");

        // STUR stalled in MEM_WR, then reset in the middle of the wait
        push(1'b0, T_STUR, 1'b0, 1'b1, E_FR,  1'b1, "rstwr_fetch");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_DEC, 1'b1, "rstwr_decode");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_MA,  1'b1, "rstwr_addr");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_MWW, 1'b1, "rstwr_wait1");
        push(1'b0, T_STUR, 1'b0, 1'b0, E_MWW, 1'b1, "rstwr_wait2");
        push(1'b1, T_STUR, 1'b0, 1'b1, E_Z,   1'b1, "rstwr_reset");
        ret_model = 4'd0;
        push(1'b0, T_B, 1'b0, 1'b0, E_FW, 1'b1, "rstwr_fetch_after");

        // Sixteen B instructions: the 4-bit retire count wraps back to 0
        for (int i = 0; i < 16; i++) begin
            add_branch(T_B, 1'b0, E_B, "wrap");
        end
        push(1'b0, T_B, 1'b0, 1'b0, E_FW, 1'b1, "wrap_final");

        // Apply every vector at the falling edge, check, then advance one clock
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle LEGv8 datapath.
- Sits directly upstream of the ALU control decoder: it produces the 2-bit ALU_op and the datapath strobes, and passes the latched 11-bit opcode through.
- Sequences fetch, decode, execute, memory and writeback over a single unified memory port with a ready handshake.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
WAIT_MAX, 255, mem_ready wait cycles before mem_timeout fires (0 disables timeout)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  11  instruction[31:21] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current mem_read/mem_write this cycle
ALU_op  out  2  00 add (address/PC), 01 branch compare, 10 R-type funct decode
opcode_out  out  11  opcode latched at DECODE, feeds ALU control
alu_src_a  out  2  00 PC, 01 regA, 10 constant zero
alu_src_b  out  2  00 regB, 01 constant 4, 10 extended immediate/shamt, 11 branch offset<<2
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_source  out  1  0 ALU result, 1 ALUOut register
iord  out  1  0 memory address = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_write  out  1  register file write
mem_to_reg  out  1  writeback source 1 = MDR, 0 = ALUOut
reg2loc  out  1  read port 2 selects Rt (1) or Rm (0)
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse on an undecodable opcode
mem_timeout  out  1  one-cycle pulse when the wait limit is hit
retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset effect: while reset=1, all strobes are forced to 0. On the next edge, state=FETCH, retired=0, wait counter=0 and opcode_out=0. Reset overrides everything in any state, including mid-memory-wait.
- Output style: Moore outputs, decoded from the state. Any strobe not listed for a state is 0.
- FETCH:
  - Strobes: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, ALU_op=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=0, next state DECODE.
- DECODE:
  - Strobes: alu_src_a=00, alu_src_b=11, ALU_op=00 (branch target into ALUOut). Latches opcode_out.
  - Dispatch:
    - LDUR 11111000010 or STUR 11111000000 → MEM_ADDR
    - ADD, SUB, AND, ORR → EXEC_R
    - LSL, LSR → EXEC_SH
    - CBZ 10110100xxx → EXEC_CBZ
    - B 000101xxxxx → EXEC_B
    - any other opcode → illegal=1 that cycle, next state FETCH; no retire, no instr_done.
- EXEC_R: alu_src_a=01, alu_src_b=00, ALU_op=10 → R_WB.
- EXEC_SH: alu_src_a=01, alu_src_b=10, ALU_op=10 → R_WB.
- R_WB: reg_write=1, mem_to_reg=0, instr_done=1 → FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, ALU_op=00, reg2loc=1.
  - LDUR → MEM_RD; STUR → MEM_WR.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, iord=1, reg2loc=1. Holds until mem_ready; then instr_done=1 → FETCH.
- EXEC_CBZ: alu_src_a=10, alu_src_b=00, reg2loc=1, ALU_op=01, pc_write_cond=1, pc_source=1, instr_done=1 → FETCH.
- EXEC_B: pc_write=1, pc_source=1, instr_done=1 → FETCH.
- Zero-wait latencies: R 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3. Each memory wait cycle adds 1.
- mem_ready is ignored in states that do not request memory.
- Wait counter:
  - Increments each cycle a request is held with mem_ready=0.
  - Clears when the request completes or the state changes.
  - When it reaches WAIT_MAX (WAIT_MAX>0): mem_timeout=1, request dropped, next state FETCH, no retire. A timeout in FETCH leaves the PC unchanged.
- retired increments on every instr_done cycle and wraps to 0 from all-ones.

Decomposition:
- Package legv8_pkg holds:
  - opcode constants (with don't-care masks for CBZ/B)
  - the state enum (4-bit encoding)
  - ALU_op encodings
  - alu_src_a, alu_src_b and pc_source select constants
- One combinational sub-module, opcode_class: maps the 11-bit opcode to a class enum {MEM_LD, MEM_ST, R_ARITH, R_SHIFT, CBZ, B, ILLEGAL}.

Test Plan:
- Reset then ADD 10001011000, mem_ready held 1 → states FETCH, DECODE, EXEC_R, R_WB; ALU_op=10 in EXEC_R; reg_write in cycle 4; retired=1.
- LDUR 11111000010, mem_ready low 3 cycles in MEM_RD → mem_read held through the wait, MEM_WB after ready, total 8 cycles, instr_done once.
- CBZ 10110100101 with zero=1, then with zero=0 → pc_write_cond=1 with ALU_op=01 and alu_src_a=10 in both cases; 3 cycles each.
- Opcode 00000000000 → illegal pulse in DECODE, back to FETCH, retired unchanged.
- reset asserted mid-wait in MEM_WR → strobes 0 that cycle, FETCH next, retired=0.
- WAIT_MAX=4 with mem_ready stuck 0 in FETCH → mem_timeout pulse on the 4th wait cycle; with CNT_W=4, 16 retires wrap retired to 0.
